// File: rtl/core_mem_responder.sv
// core_mem_responder
// Memory-side responder for the cores' request interface. Single-cycle read
// and write pulses from each core are captured into per-core slots. The slots
// are arbitrated onto one single-port RAM in this order: host load first, then
// core writes, then core reads. Each read returns as a registered one-cycle
// ready pulse together with its data.
module core_mem_responder #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int DEPTH     = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    rd_req,
    input  logic [NUM_CORES*AW-1:0] rd_addr,
    output logic [NUM_CORES-1:0]    rd_ready,
    output logic [NUM_CORES*DW-1:0] rd_data,
    input  logic [NUM_CORES-1:0]    wr_req,
    input  logic [NUM_CORES*AW-1:0] wr_addr,
    input  logic [NUM_CORES*DW-1:0] wr_data,
    input  logic                    load_en,
    input  logic [AW-1:0]           load_addr,
    input  logic [DW-1:0]           load_data,
    output logic                    busy,
    output logic [NUM_CORES-1:0]    err
);

    localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_CORES - 1);

    // The single RAM operation performed at the coming edge.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOAD,
        OP_WRITE,
        OP_READ
    } op_e;

    // Slot state: valid bits are control and carry a reset. Addresses and data
    // are payload and matter only while the matching valid bit is set.
    logic [NUM_CORES-1:0] rd_vld_q, rd_vld_d;
    logic [NUM_CORES-1:0] wr_vld_q, wr_vld_d;
    logic [IW-1:0]        rd_idx_q [NUM_CORES];
    logic [IW-1:0]        rd_idx_d [NUM_CORES];
    logic [IW-1:0]        wr_idx_q [NUM_CORES];
    logic [IW-1:0]        wr_idx_d [NUM_CORES];
    logic [DW-1:0]        wr_dat_q [NUM_CORES];
    logic [DW-1:0]        wr_dat_d [NUM_CORES];

    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [NUM_CORES-1:0] err_q, err_d;

    logic [NUM_CORES-1:0]    rd_ready_q;
    logic [NUM_CORES*DW-1:0] rd_data_q;

    logic [DW-1:0] mem [DEPTH];

    op_e                  op;
    logic [PW-1:0]        wr_win, rd_win;
    logic [NUM_CORES-1:0] wr_gnt, rd_gnt;

    // Only the low index bits of each address reach the RAM. The upper bits
    // wrap, so they are deliberately left unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr, wr_addr, load_addr};

    // Returns the first set bit of valid, scanning upward from ptr with wrap.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_CORES-1:0] valid,
                                              input logic [PW-1:0]        ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(ptr) + k) % NUM_CORES;
            if (!found && valid[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Returns the round-robin successor of a winner: winner + 1, mod NUM_CORES.
    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] win);
        return (win == LAST) ? '0 : win + 1'b1;
    endfunction

    // Arbitration: host load, then round-robin writes, then round-robin reads.
    always_comb begin
        // NOTE: every output gets a default before any branch; a path that leaves one unassigned infers a latch.
        op     = OP_NONE;
        wr_gnt = '0;
        rd_gnt = '0;
        wr_win = rr_pick(wr_vld_q, wr_ptr_q);
        rd_win = rr_pick(rd_vld_q, rd_ptr_q);
        if (load_en) begin
            op = OP_LOAD;
        end else if (|wr_vld_q) begin
            op             = OP_WRITE;
            wr_gnt[wr_win] = 1'b1;
        end else if (|rd_vld_q) begin
            op             = OP_READ;
            rd_gnt[rd_win] = 1'b1;
        end
    end

    // Slot next state: a granted slot frees, an incoming pulse fills a free
    // slot, and a pulse hitting a still-pending slot is dropped and flagged.
    always_comb begin
        // NOTE: blocking assignments here. Later statements must see the earlier updates within this block.
        rd_vld_d = rd_vld_q & ~rd_gnt;
        wr_vld_d = wr_vld_q & ~wr_gnt;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        wr_dat_d = wr_dat_q;
        err_d    = err_q;
        rd_ptr_d = (op == OP_READ)  ? rr_next(rd_win) : rd_ptr_q;
        wr_ptr_d = (op == OP_WRITE) ? rr_next(wr_win) : wr_ptr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rd_req[i]) begin
                if (rd_vld_d[i]) begin
                    err_d[i] = 1'b1;
                end else begin
                    rd_vld_d[i] = 1'b1;
                    rd_idx_d[i] = rd_addr[i*AW +: IW];
                end
            end
            if (wr_req[i]) begin
                if (wr_vld_d[i]) begin
                    err_d[i] = 1'b1;
                end else begin
                    wr_vld_d[i] = 1'b1;
                    wr_idx_d[i] = wr_addr[i*AW +: IW];
                    wr_dat_d[i] = wr_data[i*DW +: DW];
                end
            end
        end
    end

    // Control state: slot valids, round-robin pointers, sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            wr_vld_q <= wr_vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    // Slot payload registers: addresses and write data.
    always_ff @(posedge clk) begin
        // NOTE: payload and RAM have no reset. The valid bits already decide what is live, and a RAM cannot be cleared in one cycle.
        rd_idx_q <= rd_idx_d;
        wr_idx_q <= wr_idx_d;
        wr_dat_q <= wr_dat_d;
    end

    // RAM write port: host load or the granted core write.
    always_ff @(posedge clk) begin
        if (op == OP_LOAD) begin
            mem[load_addr[IW-1:0]] <= load_data;
        end else if (op == OP_WRITE) begin
            mem[wr_idx_q[wr_win]] <= wr_dat_q[wr_win];
        end
    end

    // Read return: one-cycle ready pulse. The data slice holds until that
    // core's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ready_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_ready_q <= rd_gnt;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (rd_gnt[i]) begin
                    rd_data_q[i*DW +: DW] <= mem[rd_idx_q[rd_win]];
                end
            end
        end
    end

    assign rd_ready = rd_ready_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
    assign busy     = |{rd_vld_q, wr_vld_q};

endmodule

// File: tb/tb_core_mem_responder.sv
// Testbench for core_mem_responder. Directed scenarios check against fixed
// expected values. Randomized traffic checks against a transaction-level
// reference model that keeps pending requests per core plus a memory array.
module tb_core_mem_responder;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    rd_req, wr_req, rd_ready, err;
    logic [N*AW-1:0] rd_addr, wr_addr;
    logic [N*DW-1:0] rd_data, wr_data;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [DW-1:0]   load_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    core_mem_responder #(.NUM_CORES(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_rd_pend [N];
    int            m_rd_addr [N];
    bit            m_wr_pend [N];
    int            m_wr_addr [N];
    logic [DW-1:0] m_wr_data [N];
    int            m_rd_ptr, m_wr_ptr;
    logic [N-1:0]  m_ready, m_err;
    logic [DW-1:0] m_data [N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_rd_pend[i] = 0;
            m_wr_pend[i] = 0;
            m_data[i]    = '0;
        end
        m_rd_ptr = 0;
        m_wr_ptr = 0;
        m_ready  = '0;
        m_err    = '0;
    endtask

    // One clock edge: serve one operation from pre-edge state, then capture.
    task automatic model_edge();
        int g;
        g       = -1;
        m_ready = '0;
        if (load_en) begin
            m_mem[int'(load_addr) % DEPTH] = load_data;
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && m_wr_pend[(m_wr_ptr + k) % N]) g = (m_wr_ptr + k) % N;
            if (g >= 0) begin
                m_mem[m_wr_addr[g] % DEPTH] = m_wr_data[g];
                m_wr_pend[g] = 0;
                m_wr_ptr     = (g + 1) % N;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && m_rd_pend[(m_rd_ptr + k) % N]) g = (m_rd_ptr + k) % N;
                if (g >= 0) begin
                    m_ready[g]   = 1'b1;
                    m_data[g]    = m_mem[m_rd_addr[g] % DEPTH];
                    m_rd_pend[g] = 0;
                    m_rd_ptr     = (g + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rd_req[i]) begin
                if (m_rd_pend[i]) m_err[i] = 1'b1;
                else begin
                    m_rd_pend[i] = 1;
                    m_rd_addr[i] = int'(rd_addr[i*AW +: AW]);
                end
            end
            if (wr_req[i]) begin
                if (m_wr_pend[i]) m_err[i] = 1'b1;
                else begin
                    m_wr_pend[i] = 1;
                    m_wr_addr[i] = int'(wr_addr[i*AW +: AW]);
                    m_wr_data[i] = wr_data[i*DW +: DW];
                end
            end
        end
    endtask

    function automatic logic [N*DW-1:0] m_data_flat();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_data[i];
        return v;
    endfunction

    function automatic logic m_busy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b = b | m_rd_pend[i] | m_wr_pend[i];
        return b;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Advance one rising edge, update the model, and return 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        rd_req    = '0;
        wr_req    = '0;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic host_load(input int addr, input logic [DW-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic set_rd(input int core, input int addr);
        rd_req[core]            = 1'b1;
        rd_addr[core*AW +: AW]  = AW'(addr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL reset rd_ready: got %b want 0", rd_ready); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset rd_data: got %h want 0", rd_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (err !== '0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic preload();
        for (int a = 0; a < DEPTH; a++) begin
            load_en   = 1'b1;
            load_addr = AW'(a + DEPTH * int'($urandom_range(0, 255)));
            load_data = DW'($urandom);
            tick();
        end
        load_en = 1'b0;
        n_checks++; if (busy !== 1'b0 || rd_ready !== '0) begin n_fail++; $display("FAIL preload idle: busy %b rd_ready %b want 0/0", busy, rd_ready); end
    endtask

    task automatic test_single_read();
        logic [N*DW-1:0] prev;
        host_load(16'h0010, 16'hBEEF);
        prev = rd_data;
        set_rd(1, 16'h0010);
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL single_read c0 ready: got %b want 0000", rd_ready); end
        tick(); clear_inputs();
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL single_read c1 ready: got %b want 0000", rd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_read c1 busy: got %b want 1", busy); end
        tick();
        n_checks++; if (rd_ready !== 4'b0010) begin n_fail++; $display("FAIL single_read c2 ready: got %b want 0010", rd_ready); end
        n_checks++; if (rd_data[1*DW +: DW] !== 16'hBEEF) begin n_fail++; $display("FAIL single_read c2 data: got %h want beef", rd_data[1*DW +: DW]); end
        n_checks++;
        if (rd_data[0 +: DW] !== prev[0 +: DW] || rd_data[2*DW +: 2*DW] !== prev[2*DW +: 2*DW]) begin
            n_fail++; $display("FAIL single_read other slices: got %h want %h (slice1 excepted)", rd_data, prev);
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_read c2 busy: got %b want 0", busy); end
        tick();
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL single_read c3 ready: got %b want 0000", rd_ready); end
        n_checks++; if (rd_data[1*DW +: DW] !== 16'hBEEF) begin n_fail++; $display("FAIL single_read c3 hold: got %h want beef", rd_data[1*DW +: DW]); end
    endtask

    task automatic test_store_fetch();
        wr_req[0]        = 1'b1;
        wr_addr[0 +: AW] = 16'h0005;
        wr_data[0 +: DW] = 16'h1234;
        tick(); clear_inputs();
        set_rd(0, 16'h0005);
        tick(); clear_inputs();
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL store_fetch c2 ready: got %b want 0000", rd_ready); end
        tick();
        n_checks++; if (rd_ready !== 4'b0001) begin n_fail++; $display("FAIL store_fetch c3 ready: got %b want 0001", rd_ready); end
        n_checks++; if (rd_data[0 +: DW] !== 16'h1234) begin n_fail++; $display("FAIL store_fetch c3 data: got %h want 1234", rd_data[0 +: DW]); end
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_r;
        apply_reset();
        for (int i = 0; i < N; i++) host_load(16'h0020 + i, DW'(16'hA000 + i));
        for (int i = 0; i < N; i++) set_rd(i, 16'h0020 + i);
        tick(); clear_inputs();
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL contention c1 ready: got %b want 0000", rd_ready); end
        for (int k = 0; k < N; k++) begin
            tick();
            exp_r    = '0;
            exp_r[k] = 1'b1;
            n_checks++; if (rd_ready !== exp_r) begin n_fail++; $display("FAIL contention c%0d ready: got %b want %b", k + 2, rd_ready, exp_r); end
            n_checks++; if (rd_data[k*DW +: DW] !== DW'(16'hA000 + k)) begin n_fail++; $display("FAIL contention core%0d data: got %h want %h", k, rd_data[k*DW +: DW], DW'(16'hA000 + k)); end
        end
        tick();
        n_checks++; if (rd_ready !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL contention drain: ready %b busy %b want 0000/0", rd_ready, busy); end
        // Second burst from cores 3 and 0: the wrapped pointer must favour core 0.
        set_rd(0, 16'h0023);
        set_rd(3, 16'h0020);
        tick(); clear_inputs();
        tick();
        n_checks++; if (rd_ready !== 4'b0001) begin n_fail++; $display("FAIL contention wrap first: got %b want 0001", rd_ready); end
        n_checks++; if (rd_data[0 +: DW] !== 16'hA003) begin n_fail++; $display("FAIL contention wrap data0: got %h want a003", rd_data[0 +: DW]); end
        tick();
        n_checks++; if (rd_ready !== 4'b1000) begin n_fail++; $display("FAIL contention wrap second: got %b want 1000", rd_ready); end
        n_checks++; if (rd_data[3*DW +: DW] !== 16'hA000) begin n_fail++; $display("FAIL contention wrap data3: got %h want a000", rd_data[3*DW +: DW]); end
        tick();
    endtask

    task automatic test_host_priority();
        set_rd(2, 16'h0030);
        tick(); clear_inputs();
        for (int c = 1; c <= 3; c++) begin
            load_en   = 1'b1;
            load_addr = 16'h0030;
            load_data = DW'(16'h5A59 + c);
            tick();
            n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL host_priority c%0d ready: got %b want 0000", c + 1, rd_ready); end
        end
        load_en = 1'b0;
        tick();
        n_checks++; if (rd_ready !== 4'b0100) begin n_fail++; $display("FAIL host_priority c5 ready: got %b want 0100", rd_ready); end
        n_checks++; if (rd_data[2*DW +: DW] !== 16'h5A5C) begin n_fail++; $display("FAIL host_priority data: got %h want 5a5c", rd_data[2*DW +: DW]); end
        tick();
    endtask

    task automatic test_overflow_wrap();
        wr_req[0]        = 1'b1;
        wr_addr[0 +: AW] = 16'h0040;
        wr_data[0 +: DW] = 16'h7777;
        set_rd(3, 16'h0110);
        tick(); clear_inputs();
        set_rd(3, 16'h0110);
        tick(); clear_inputs();
        n_checks++; if (err !== 4'b1000) begin n_fail++; $display("FAIL overflow err: got %b want 1000", err); end
        n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL overflow c2 ready: got %b want 0000", rd_ready); end
        tick();
        n_checks++; if (rd_ready !== 4'b1000) begin n_fail++; $display("FAIL overflow c3 ready: got %b want 1000", rd_ready); end
        n_checks++; if (rd_data[3*DW +: DW] !== 16'hBEEF) begin n_fail++; $display("FAIL wrap data: got %h want beef", rd_data[3*DW +: DW]); end
        tick();
        n_checks++; if (rd_ready !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL overflow single pulse: ready %b busy %b want 0000/0", rd_ready, busy); end
        // A pulse arriving in its slot's grant cycle refills the slot legally.
        set_rd(1, 16'h0021);
        tick(); clear_inputs();
        set_rd(1, 16'h0022);
        tick(); clear_inputs();
        n_checks++; if (rd_ready !== 4'b0010 || rd_data[1*DW +: DW] !== 16'hA001) begin n_fail++; $display("FAIL refill first: ready %b data %h want 0010/a001", rd_ready, rd_data[1*DW +: DW]); end
        tick();
        n_checks++; if (rd_ready !== 4'b0010 || rd_data[1*DW +: DW] !== 16'hA002) begin n_fail++; $display("FAIL refill second: ready %b data %h want 0010/a002", rd_ready, rd_data[1*DW +: DW]); end
        n_checks++; if (err !== 4'b1000) begin n_fail++; $display("FAIL refill err: got %b want 1000", err); end
        tick();
    endtask

    task automatic test_reset_midop();
        set_rd(0, 16'h0020);
        set_rd(1, 16'h0021);
        tick(); clear_inputs();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0 || err !== '0) begin n_fail++; $display("FAIL reset_midop state: busy %b err %b want 0/0000", busy, err); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_midop data: got %h want 0", rd_data); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (rd_ready !== '0) begin n_fail++; $display("FAIL reset_midop ready +%0d: got %b want 0000", c, rd_ready); end
            tick();
        end
        set_rd(2, 16'h0010);
        tick(); clear_inputs();
        tick();
        n_checks++; if (rd_ready !== 4'b0100 || rd_data[2*DW +: DW] !== 16'hBEEF) begin n_fail++; $display("FAIL reset_midop ram kept: ready %b data %h want 0100/beef", rd_ready, rd_data[2*DW +: DW]); end
        tick();
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            apply_reset();
            for (int c = 0; c < 600; c++) begin
                load_en   = ($urandom_range(0, 31) == 0);
                load_addr = AW'($urandom);
                load_data = DW'($urandom);
                for (int i = 0; i < N; i++) begin
                    rd_req[i]           = ($urandom_range(0, 7) == 0);
                    rd_addr[i*AW +: AW] = AW'($urandom);
                    wr_req[i]           = ($urandom_range(0, 15) == 0);
                    wr_addr[i*AW +: AW] = AW'($urandom);
                    wr_data[i*DW +: DW] = DW'($urandom);
                end
                tick();
                n_checks++; if (rd_ready !== m_ready) begin n_fail++; $display("FAIL random ready p%0d c%0d: got %b want %b", p, c, rd_ready, m_ready); end
                n_checks++; if (rd_data !== m_data_flat()) begin n_fail++; $display("FAIL random data p%0d c%0d: got %h want %h", p, c, rd_data, m_data_flat()); end
                n_checks++; if (busy !== m_busy()) begin n_fail++; $display("FAIL random busy p%0d c%0d: got %b want %b", p, c, busy, m_busy()); end
                n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL random err p%0d c%0d: got %b want %b", p, c, err, m_err); end
            end
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_single_read();
        test_store_fetch();
        test_contention();
        test_host_priority();
        test_overflow_wrap();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the cores' request interface: read port (memRead1/memIn1/memReady1/memOut1) and write port (memWrite/memWriteAddr/memWriteData).
- Captures single-cycle request pulses from NUM_CORES cores into per-core slots and arbitrates them onto one single-port RAM.
- Returns each read as a registered one-cycle ready pulse with data.
- Also provides a host load port, used to preload programs before cores are released.

Parameters:
- NUM_CORES, 4, number of attached cores (>=1).
- AW, 16, request address width.
- DW, 16, data width.
- DEPTH, 256, RAM words (power of 2); index = addr[log2(DEPTH)-1:0], upper bits ignored (wrap).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  NUM_CORES  per-core read pulse (core memRead1).
- rd_addr  in  NUM_CORES*AW  per-core read address, slice i = core i (memIn1).
- rd_ready  out  NUM_CORES  per-core one-cycle read-done pulse (memReady1).
- rd_data  out  NUM_CORES*DW  per-core read data, valid while rd_ready[i] (memOut1).
- wr_req  in  NUM_CORES  per-core write pulse (memWrite).
- wr_addr  in  NUM_CORES*AW  per-core write address.
- wr_data  in  NUM_CORES*DW  per-core write data.
- load_en  in  1  host write strobe, highest priority.
- load_addr  in  AW  host write address.
- load_data  in  DW  host write data.
- busy  out  1  any slot pending.
- err  out  NUM_CORES  sticky per-core overflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - All slots empty; rd_ready=0, rd_data=0, busy=0, err=0; RR pointers=0.
  - RAM contents not reset.
  - Reset mid-operation drops all pending work; no rd_ready pulse after reset.
- Capture: on each edge, per core, a rd_req or wr_req pulse latches address (and data) into that core's read or write slot.
  - A request is capture-only in its own cycle and is eligible for grant from the next cycle.
  - Requests are pulses: the core does not hold them, so a missed capture is a lost request.
- Overflow: a pulse arriving while that core's same-type slot is still pending (and not being granted that cycle) is dropped; err[i] is set and stays set until reset.
  - A pulse arriving in the cycle its slot is granted refills the slot legally.
- Grant: at most one RAM operation per cycle, chosen in this priority order:
  1. load_en: write load_data to load_addr. All core slots hold.
  2. Else any pending write slot: round-robin among cores, starting at wr pointer; pointer moves to winner+1 mod NUM_CORES.
  3. Else any pending read slot: round-robin, separate rd pointer, same rule.
- Ordering: writes before reads guarantees a core's own store is visible to its next fetch or load.
  - Core protocol bounds this to at most one write and one read outstanding per core, so reads cannot starve.
- Read latency: RAM read at the grant edge. rd_ready[i]=1 for exactly one cycle in the cycle after grant; rd_data slice i holds the RAM word in that cycle and keeps it afterwards.
  - Minimum: request in cycle 0, captured at edge 0, granted cycle 1, rd_ready in cycle 2.
  - rd_ready is never asserted in the request cycle itself.
- Write: RAM updated at the grant edge. A read granted the following cycle returns the new data.
- rd_ready pulses are registered; never more than one bit of rd_ready is high per cycle.
- busy = OR of all slot-valid bits, registered state.

Test Plan:
- Single read: RAM[0x10]=0xBEEF via load; core1 rd_req pulse addr 0x0010 at cycle 0 -> rd_ready=0b0010 in cycle 2 only, rd_data[1]=0xBEEF; other slices unchanged.
- Store-then-fetch: core0 wr 0x0005<-0x1234 at cycle 0, rd 0x0005 at cycle 1 -> write granted cycle 1, read granted cycle 2, rd_ready[0] cycle 3 with 0x1234.
- Contention: all 4 cores rd_req at cycle 0 to distinct preloaded addresses -> rd_ready = 0b0001, 0b0010, 0b0100, 0b1000 in cycles 2,3,4,5; next burst starts with core0 (pointer wrapped).
- Host priority: load_en held cycles 1-3 while core2 read pending -> core2 grant delayed to cycle 4, rd_ready[2] cycle 5; load data visible if same address.
- Overflow and wrap: core3 two rd_req pulses back-to-back while core0 write pending -> err[3]=1, only one rd_ready[3]; read addr 0x0110 with DEPTH=256 returns RAM[0x10].
- Reset mid-op: rst_n low for 1 cycle while 2 reads pending -> rd_ready stays 0, busy=0, err=0 afterwards; RAM preserved.
